// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, FSM states and
// the strobe bundle the output decoder fills in.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_BRX  = 5'b10010;
    localparam logic [4:0] OP_MFHI = 5'b10100;
    localparam logic [4:0] OP_MFLO = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [5:0] {
        S_FETCH0, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_ALU_T3, S_ALU_T4, S_ALU_T5,
        S_ADDI_T3, S_ADDI_T4, S_ADDI_T5,
        S_LD_T3, S_LD_T4, S_LD_T5, S_LD_T6, S_LD_T7, S_LD_T8,
        S_ST_T3, S_ST_T4, S_ST_T5, S_ST_T6, S_ST_T7,
        S_BR_T3, S_BR_T4, S_BR_T5, S_BR_T6_TAKEN, S_BR_T6_SKIP,
        S_IN_T3, S_OUT_T3,
        S_MD_T3, S_MD_T4, S_MD_T5, S_MD_T6, S_MFHI_T3, S_MFLO_T3,
        S_HALT
    } state_t;

    typedef struct packed {
        logic run;
        logic gra, grb, grc, rin, rout, baout;
        logic pcout, zlowout, zhighout, hiout, loout, mdrout, in_portout, cout;
        logic marin, pcin, mdrin, irin, yin, hiin, loin, zin_low, zin_high;
        logic inportenable, outportenable;
        logic incpc, read, write, conin;
    } strobes_t;

endpackage

// File: rtl/control_unit.sv
// Hardwired Moore control unit: fetch/decode/execute sequencer for the CPU.
// Define CONTROL_UNIT_MULDIV_EN to enable mul/div/mfhi/mflo sequencing.
module control_unit
    import cpu_pkg::*;
(
    input  logic        Clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        CON,
    input  logic        Stop,
    output logic        Run,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIout,
    output logic        LOout,
    output logic        MDRout,
    output logic        In_Portout,
    output logic        Cout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        Zin_low,
    output logic        Zin_high,
    output logic        inPortenable,
    output logic        outPortenable,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        ConIn
);

    state_t     state_q, state_d;
    strobes_t   s;
    logic [4:0] opcode;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];

    always_ff @(posedge Clock) begin
        if (clear) state_q <= S_FETCH0;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH0: state_d = Stop ? S_HALT : S_FETCH1;
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: state_d = S_FETCH3;
            S_FETCH3: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_ALU_T3;
                    OP_ADDI: state_d = S_ADDI_T3;
                    OP_LD:   state_d = S_LD_T3;
                    OP_ST:   state_d = S_ST_T3;
                    OP_BRX:  state_d = S_BR_T3;
                    OP_IN:   state_d = S_IN_T3;
                    OP_OUT:  state_d = S_OUT_T3;
                    OP_HALT: state_d = S_HALT;
`ifdef CONTROL_UNIT_MULDIV_EN
                    OP_MUL, OP_DIV: state_d = S_MD_T3;
                    OP_MFHI: state_d = S_MFHI_T3;
                    OP_MFLO: state_d = S_MFLO_T3;
`endif
                    default: state_d = S_FETCH0;
                endcase
            end
            S_ALU_T3:  state_d = S_ALU_T4;
            S_ALU_T4:  state_d = S_ALU_T5;
            S_ADDI_T3: state_d = S_ADDI_T4;
            S_ADDI_T4: state_d = S_ADDI_T5;
            S_LD_T3:   state_d = S_LD_T4;
            S_LD_T4:   state_d = S_LD_T5;
            S_LD_T5:   state_d = S_LD_T6;
            S_LD_T6:   state_d = S_LD_T7;
            S_LD_T7:   state_d = S_LD_T8;
            S_ST_T3:   state_d = S_ST_T4;
            S_ST_T4:   state_d = S_ST_T5;
            S_ST_T5:   state_d = S_ST_T6;
            S_ST_T6:   state_d = S_ST_T7;
            S_BR_T3:   state_d = S_BR_T4;
            S_BR_T4:   state_d = S_BR_T5;
            // CON was latched in T3, so the branch decision is stable here
            S_BR_T5:   state_d = CON ? S_BR_T6_TAKEN : S_BR_T6_SKIP;
            S_MD_T3:   state_d = S_MD_T4;
            S_MD_T4:   state_d = S_MD_T5;
            S_MD_T5:   state_d = S_MD_T6;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_FETCH0;
        endcase
    end

    always_comb begin
        s     = '0;
        s.run = 1'b1;
        case (state_q)
            S_FETCH0: begin s.pcout = 1'b1; s.marin = 1'b1; s.incpc = 1'b1; s.zin_low = 1'b1; end
            S_FETCH1: s.read = 1'b1;
            S_FETCH2: begin s.read = 1'b1; s.mdrin = 1'b1; s.zlowout = 1'b1; s.pcin = 1'b1; end
            S_FETCH3: begin s.mdrout = 1'b1; s.irin = 1'b1; end
            S_ALU_T3, S_ADDI_T3: begin s.grb = 1'b1; s.rout = 1'b1; s.yin = 1'b1; end
            S_ALU_T4: begin s.grc = 1'b1; s.rout = 1'b1; s.zin_low = 1'b1; end
            S_ADDI_T4, S_LD_T4, S_ST_T4, S_BR_T5: begin s.cout = 1'b1; s.zin_low = 1'b1; end
            S_ALU_T5, S_ADDI_T5: begin s.zlowout = 1'b1; s.gra = 1'b1; s.rin = 1'b1; end
            S_LD_T3, S_ST_T3: begin s.grb = 1'b1; s.baout = 1'b1; s.yin = 1'b1; end
            S_LD_T5, S_ST_T5: begin s.zlowout = 1'b1; s.marin = 1'b1; end
            S_LD_T6: s.read = 1'b1;
            S_LD_T7: begin s.read = 1'b1; s.mdrin = 1'b1; end
            S_LD_T8: begin s.mdrout = 1'b1; s.gra = 1'b1; s.rin = 1'b1; end
            S_ST_T6: begin s.gra = 1'b1; s.rout = 1'b1; s.mdrin = 1'b1; end
            S_ST_T7: s.write = 1'b1;
            S_BR_T3: begin s.gra = 1'b1; s.rout = 1'b1; s.conin = 1'b1; end
            S_BR_T4: begin s.pcout = 1'b1; s.yin = 1'b1; end
            S_BR_T6_TAKEN: begin s.zlowout = 1'b1; s.pcin = 1'b1; end
            S_IN_T3: begin s.in_portout = 1'b1; s.gra = 1'b1; s.rin = 1'b1; end
            S_OUT_T3: begin s.gra = 1'b1; s.rout = 1'b1; s.outportenable = 1'b1; end
`ifdef CONTROL_UNIT_MULDIV_EN
            S_MD_T3: begin s.gra = 1'b1; s.rout = 1'b1; s.yin = 1'b1; end
            S_MD_T4: begin s.grb = 1'b1; s.rout = 1'b1; s.zin_low = 1'b1; s.zin_high = 1'b1; end
            S_MD_T5: begin s.zlowout = 1'b1; s.loin = 1'b1; end
            S_MD_T6: begin s.zhighout = 1'b1; s.hiin = 1'b1; end
            S_MFHI_T3: begin s.hiout = 1'b1; s.gra = 1'b1; s.rin = 1'b1; end
            S_MFLO_T3: begin s.loout = 1'b1; s.gra = 1'b1; s.rin = 1'b1; end
`endif
            S_HALT: s.run = 1'b0;
            default: ;
        endcase
    end

    assign Run           = s.run;
    assign Gra           = s.gra;
    assign Grb           = s.grb;
    assign Grc           = s.grc;
    assign Rin           = s.rin;
    assign Rout          = s.rout;
    assign BAout         = s.baout;
    assign PCout         = s.pcout;
    assign Zlowout       = s.zlowout;
    assign Zhighout      = s.zhighout;
    assign HIout         = s.hiout;
    assign LOout         = s.loout;
    assign MDRout        = s.mdrout;
    assign In_Portout    = s.in_portout;
    assign Cout          = s.cout;
    assign MARin         = s.marin;
    assign PCin          = s.pcin;
    assign MDRin         = s.mdrin;
    assign IRin          = s.irin;
    assign Yin           = s.yin;
    assign HIin          = s.hiin;
    assign LOin          = s.loin;
    assign Zin_low       = s.zin_low;
    assign Zin_high      = s.zin_high;
    assign inPortenable  = s.inportenable;
    assign outPortenable = s.outportenable;
    assign IncPC         = s.incpc;
    assign Read          = s.read;
    assign Write         = s.write;
    assign ConIn         = s.conin;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-opcode cycle-length table, randomized instruction
// stream against a strobe-list model, and hand-written halt/clear/Stop sequences.
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        clear, CON, Stop;
    logic [31:0] IR;
    logic Run, Gra, Grb, Grc, Rin, Rout, BAout, PCout, Zlowout, Zhighout, HIout, LOout;
    logic MDRout, In_Portout, Cout, MARin, PCin, MDRin, IRin, Yin, HIin, LOin;
    logic Zin_low, Zin_high, inPortenable, outPortenable, IncPC, Read, Write, ConIn;

    always #5 Clock = ~Clock;

    control_unit dut (
        .Clock(Clock), .clear(clear), .IR(IR), .CON(CON), .Stop(Stop), .Run(Run),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIout(HIout), .LOout(LOout),
        .MDRout(MDRout), .In_Portout(In_Portout), .Cout(Cout), .MARin(MARin), .PCin(PCin),
        .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
        .Zin_low(Zin_low), .Zin_high(Zin_high), .inPortenable(inPortenable),
        .outPortenable(outPortenable), .IncPC(IncPC), .Read(Read), .Write(Write), .ConIn(ConIn)
    );

    // one bit per observable output
    localparam logic [31:0] RUN = 32'd1 << 0,  GRA = 32'd1 << 1,  GRB = 32'd1 << 2,  GRC = 32'd1 << 3;
    localparam logic [31:0] RIN = 32'd1 << 4,  ROUT = 32'd1 << 5, BAO = 32'd1 << 6,  PCO = 32'd1 << 7;
    localparam logic [31:0] ZLO = 32'd1 << 8,  ZHO = 32'd1 << 9,  HIO = 32'd1 << 10, LOO = 32'd1 << 11;
    localparam logic [31:0] MDRO = 32'd1 << 12, INPO = 32'd1 << 13, CO = 32'd1 << 14, MARI = 32'd1 << 15;
    localparam logic [31:0] PCI = 32'd1 << 16, MDRI = 32'd1 << 17, IRI = 32'd1 << 18, YI = 32'd1 << 19;
    localparam logic [31:0] HII = 32'd1 << 20, LOI = 32'd1 << 21, ZIL = 32'd1 << 22, ZIH = 32'd1 << 23;
    localparam logic [31:0] INPE = 32'd1 << 24, OUTPE = 32'd1 << 25, INC = 32'd1 << 26, RD = 32'd1 << 27;
    localparam logic [31:0] WR = 32'd1 << 28, CONI = 32'd1 << 29;
    localparam logic [31:0] F0W = RUN | PCO | MARI | INC | ZIL;

    logic [31:0] vec;
    assign vec = {2'b00, ConIn, Write, Read, IncPC, outPortenable, inPortenable, Zin_high, Zin_low,
                  LOin, HIin, Yin, IRin, MDRin, PCin, MARin, Cout, In_Portout, MDRout, LOout,
                  HIout, Zhighout, Zlowout, PCout, BAout, Rout, Rin, Grc, Grb, Gra, Run};

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Strobe list per cycle, written straight from the instruction descriptions.
    task automatic build_seq(input logic [4:0] op, input logic con);
        exp_q = {};
        exp_q.push_back(F0W);
        exp_q.push_back(RUN | RD);
        exp_q.push_back(RUN | RD | MDRI | ZLO | PCI);
        exp_q.push_back(RUN | MDRO | IRI);
        exp_q.push_back(RUN);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                exp_q.push_back(RUN | GRB | ROUT | YI);
                exp_q.push_back(RUN | GRC | ROUT | ZIL);
                exp_q.push_back(RUN | ZLO | GRA | RIN);
            end
            5'b00001: begin
                exp_q.push_back(RUN | GRB | ROUT | YI);
                exp_q.push_back(RUN | CO | ZIL);
                exp_q.push_back(RUN | ZLO | GRA | RIN);
            end
            5'b00000, 5'b00010: begin
                exp_q.push_back(RUN | GRB | BAO | YI);
                exp_q.push_back(RUN | CO | ZIL);
                exp_q.push_back(RUN | ZLO | MARI);
                if (op == 5'b00000) begin
                    exp_q.push_back(RUN | RD);
                    exp_q.push_back(RUN | RD | MDRI);
                    exp_q.push_back(RUN | MDRO | GRA | RIN);
                end else begin
                    exp_q.push_back(RUN | GRA | ROUT | MDRI);
                    exp_q.push_back(RUN | WR);
                end
            end
            5'b10010: begin
                exp_q.push_back(RUN | GRA | ROUT | CONI);
                exp_q.push_back(RUN | PCO | YI);
                exp_q.push_back(RUN | CO | ZIL);
                exp_q.push_back(con ? (RUN | ZLO | PCI) : RUN);
            end
            5'b10110: exp_q.push_back(RUN | INPO | GRA | RIN);
            5'b10111: exp_q.push_back(RUN | GRA | ROUT | OUTPE);
`ifdef CONTROL_UNIT_MULDIV_EN
            5'b01111, 5'b10000: begin
                exp_q.push_back(RUN | GRA | ROUT | YI);
                exp_q.push_back(RUN | GRB | ROUT | ZIL | ZIH);
                exp_q.push_back(RUN | ZLO | LOI);
                exp_q.push_back(RUN | ZHO | HII);
            end
            5'b10100: exp_q.push_back(RUN | HIO | GRA | RIN);
            5'b10101: exp_q.push_back(RUN | LOO | GRA | RIN);
`endif
            default: ;
        endcase
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge Clock);
        clear = 1'b0;
    endtask

    typedef struct {
        logic [4:0] op;
        logic       con;
        int         len;
    } len_vec_t;

    initial begin
        len_vec_t tbl[$];
        logic [4:0] ops[15];
        clear = 1'b1; Stop = 1'b0; CON = 1'b0; IR = '0;
        ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01111,
                5'b10000, 5'b10010, 5'b10100, 5'b10101, 5'b10110, 5'b10111, 5'b11010};
        @(negedge Clock);
        @(negedge Clock);
        clear = 1'b0;
        check("reset_fetch0", vec, F0W);

        // cycles from FETCH0 to the next FETCH0
        tbl.push_back('{5'b00011, 1'b0, 8});
        tbl.push_back('{5'b00100, 1'b1, 8});
        tbl.push_back('{5'b00101, 1'b0, 8});
        tbl.push_back('{5'b00110, 1'b0, 8});
        tbl.push_back('{5'b00001, 1'b0, 8});
        tbl.push_back('{5'b00000, 1'b0, 11});
        tbl.push_back('{5'b00010, 1'b0, 10});
        tbl.push_back('{5'b10010, 1'b0, 9});
        tbl.push_back('{5'b10010, 1'b1, 9});
        tbl.push_back('{5'b10110, 1'b0, 6});
        tbl.push_back('{5'b10111, 1'b0, 6});
        tbl.push_back('{5'b11010, 1'b0, 5});
        tbl.push_back('{5'b11111, 1'b0, 5});
`ifdef CONTROL_UNIT_MULDIV_EN
        tbl.push_back('{5'b01111, 1'b0, 9});
        tbl.push_back('{5'b10000, 1'b0, 9});
        tbl.push_back('{5'b10100, 1'b0, 6});
`else
        tbl.push_back('{5'b01111, 1'b0, 5});
        tbl.push_back('{5'b10000, 1'b0, 5});
        tbl.push_back('{5'b10100, 1'b0, 5});
`endif
        foreach (tbl[k]) begin
            int cnt;
            IR  = {tbl[k].op, 27'h5a5a5a5};
            CON = tbl[k].con;
            cnt = 0;
            do begin
                @(negedge Clock);
                cnt++;
            end while (vec !== F0W && cnt < 40);
            check($sformatf("len_op%b_con%0d", tbl[k].op, tbl[k].con), 32'(cnt), 32'(tbl[k].len));
        end

        // random instruction stream, every cycle checked against the strobe model
        for (int n = 0; n < 60; n++) begin
            logic [4:0] op;
            logic       con;
            if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(0, 31));
            else                           op = ops[$urandom_range(0, 14)];
            if (op == 5'b11011) op = 5'b11010;
            con = 1'($urandom_range(0, 1));
            IR  = {op, 27'($urandom)};
            CON = con;
            build_seq(op, con);
            foreach (exp_q[i]) begin
                check($sformatf("rand_op%b_c%0d", op, i), vec, exp_q[i]);
                @(negedge Clock);
            end
        end

        // halt opcode: fetch/decode, then parked with Run low until clear
        IR = {5'b11011, 27'd0};
        build_seq(5'b11011, 1'b0);
        foreach (exp_q[i]) begin
            check("halt_fetch", vec, exp_q[i]);
            @(negedge Clock);
        end
        for (int i = 0; i < 3; i++) begin
            check("halt_op_idle", vec, 32'd0);
            @(negedge Clock);
        end
        do_clear();
        check("halt_op_clear", vec, F0W);

        // Stop in FETCH0: HALT held for 20 cycles, then clear recovers
        Stop = 1'b1;
        @(negedge Clock);
        Stop = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("stop_halt", vec, 32'd0);
            @(negedge Clock);
        end
        do_clear();
        check("stop_clear", vec, F0W);

        // clear during st T6 aborts before the Write cycle
        IR = {5'b00010, 27'd7};
        build_seq(5'b00010, 1'b0);
        for (int i = 0; i < 9; i++) begin
            check("st_pre_clear", vec, exp_q[i]);
            if (i == 8) clear = 1'b1;
            @(negedge Clock);
        end
        clear = 1'b0;
        check("st_clear_fetch0", vec, F0W);

        // Stop outside FETCH0 is ignored; clear beats Stop
        IR = {5'b00011, 27'd1};
        build_seq(5'b00011, 1'b0);
        foreach (exp_q[i]) begin
            check("stop_ignored", vec, exp_q[i]);
            if (i == 1) Stop = 1'b1;
            if (i == 7) Stop = 1'b0;
            @(negedge Clock);
        end
        check("stop_ignored_f0", vec, F0W);
        Stop = 1'b1;
        clear = 1'b1;
        @(negedge Clock);
        clear = 1'b0;
        Stop = 1'b0;
        check("clear_over_stop", vec, F0W);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
